// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory arbiter:
//   state_t        - arbiter FSM states
//   port_id_t      - identifies the fetch port or the data port
//   RD_LAT_DEFAULT - default memory read latency in cycles
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Encoding matches the IorD output: 0 = fetch, 1 = data.
    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_id_t;

    localparam int RD_LAT_DEFAULT = 2;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin pick between the fetch and data requesters.
// Ports:
//   req_if     in  fetch port request
//   req_d      in  data port request
//   last_grant in  port granted most recently
//   winner     out port to grant (only meaningful when a request is present)
// -----------------------------------------------------------------------------
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic     req_if,
    input  logic     req_d,
    input  port_id_t last_grant,
    output port_id_t winner
);

    // A lone requester wins outright; a tie goes to the port not granted last.
    always_comb begin
        winner = PORT_IF;
        if (req_if && req_d) begin
            winner = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
        end else if (req_d) begin
            winner = PORT_D;
        end else begin
            winner = PORT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single-port memory between an instruction-fetch port (read
// only) and a data port (load/store). One transaction at a time:
// IDLE -> READ (RD_LAT cycles) or WRITE (1 cycle) -> RESP (Ack pulse) -> IDLE.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   IF_Req/IF_Addr             fetch request and address
//   IF_Ack/IF_RData            fetch completion pulse and fetched word
//   D_Req/D_Write/D_Addr/D_WData  data request, store flag, address, data
//   D_Ack/D_RData              data completion pulse and loaded word
//   Mem_Addr/Mem_WData/Mem_Write  memory address, write data, write strobe
//   Mem_RData                  memory read data
//   IorD                       0 = fetch owns memory, 1 = data owns memory
//   Busy                       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = RD_LAT_DEFAULT
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IF_Req,
    input  logic [ADDR_W-1:0] IF_Addr,
    output logic              IF_Ack,
    output logic [DATA_W-1:0] IF_RData,
    input  logic              D_Req,
    input  logic              D_Write,
    input  logic [ADDR_W-1:0] D_Addr,
    input  logic [DATA_W-1:0] D_WData,
    output logic              D_Ack,
    output logic [DATA_W-1:0] D_RData,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    output logic              Mem_Write,
    input  logic [DATA_W-1:0] Mem_RData,
    output logic              IorD,
    output logic              Busy
);

    // Wait-counter value on the final READ cycle (RD_LAT is 1..7).
    localparam logic [2:0] LAST_WAIT = 3'(RD_LAT - 1);

    state_t            state_r;
    logic [2:0]        wait_cnt_r;
    port_id_t          last_grant_r;
    logic              if_ack_r;
    logic              d_ack_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              mem_write_r;
    logic              iord_r;
    logic              busy_r;

    port_id_t          winner_s;
    logic              any_req_s;
    logic              grant_d_s;

    rr_arb2 u_rr_arb2 (
        .req_if     (IF_Req),
        .req_d      (D_Req),
        .last_grant (last_grant_r),
        .winner     (winner_s)
    );

    assign any_req_s = IF_Req | D_Req;
    assign grant_d_s = (winner_s == PORT_D);

    // Arbitration FSM with its wait counter and every registered output.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= 3'd0;
            last_grant_r <= PORT_D;   // first tie after reset goes to fetch
            if_ack_r     <= 1'b0;
            d_ack_r      <= 1'b0;
            if_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r    <= {DATA_W{1'b0}};
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            mem_write_r  <= 1'b0;
            iord_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            // Acks are single-cycle pulses; only the READ/WRITE exits raise them.
            if_ack_r <= 1'b0;
            d_ack_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        last_grant_r <= winner_s;
                        iord_r       <= grant_d_s;
                        mem_addr_r   <= grant_d_s ? D_Addr : IF_Addr;
                        // Fetch never writes, so its write data is forced to zero.
                        mem_wdata_r  <= grant_d_s ? D_WData : {DATA_W{1'b0}};
                        wait_cnt_r   <= 3'd0;
                        busy_r       <= 1'b1;
                        if (grant_d_s && D_Write) begin
                            state_r     <= ST_WRITE;
                            mem_write_r <= 1'b1;
                        end else begin
                            state_r     <= ST_READ;
                            mem_write_r <= 1'b0;
                        end
                    end else begin
                        state_r     <= ST_IDLE;
                        mem_write_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                ST_READ: begin
                    mem_write_r <= 1'b0;
                    if (wait_cnt_r == LAST_WAIT) begin
                        // Memory data is valid on the last READ cycle.
                        if (iord_r) begin
                            d_rdata_r <= Mem_RData;
                            d_ack_r   <= 1'b1;
                        end else begin
                            if_rdata_r <= Mem_RData;
                            if_ack_r   <= 1'b1;
                        end
                        wait_cnt_r <= 3'd0;
                        state_r    <= ST_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 3'd1;
                        state_r    <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    mem_write_r <= 1'b0;
                    if (iord_r) begin
                        d_ack_r <= 1'b1;
                    end else begin
                        if_ack_r <= 1'b1;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    mem_write_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    mem_write_r <= 1'b0;
                    busy_r      <= 1'b0;
                    wait_cnt_r  <= 3'd0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign IF_Ack    = if_ack_r;
    assign IF_RData  = if_rdata_r;
    assign D_Ack     = d_ack_r;
    assign D_RData   = d_rdata_r;
    assign Mem_Addr  = mem_addr_r;
    assign Mem_WData = mem_wdata_r;
    assign Mem_Write = mem_write_r;
    assign IorD      = iord_r;
    assign Busy      = busy_r;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter RD_LAT, default 2, memory read latency in cycles, legal range 1..7.
REQ-004 SHALL have ports:
  Clk  in  1  single clock, all state updates on its rising edge.
  Reset  in  1  synchronous, active-high reset.
  IF_Req  in  1  instruction-fetch read request, held high until IF_Ack.
  IF_Addr  in  ADDR_W  fetch address.
  IF_Ack  out  1  one-cycle completion pulse for the fetch port.
  IF_RData  out  DATA_W  fetched word.
  D_Req  in  1  data request, held high until D_Ack.
  D_Write  in  1  1 = store, 0 = load.
  D_Addr  in  ADDR_W  data address.
  D_WData  in  DATA_W  store data.
  D_Ack  out  1  one-cycle completion pulse for the data port.
  D_RData  out  DATA_W  loaded word.
  Mem_Addr  out  ADDR_W  address to the single-port memory.
  Mem_WData  out  DATA_W  write data to memory.
  Mem_Write  out  1  memory write strobe.
  Mem_RData  in  DATA_W  memory read data.
  IorD  out  1  0 = fetch port owns memory, 1 = data port owns memory.
  Busy  out  1  high in every state except IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, READ, WRITE and RESP.
REQ-006 In IDLE, with exactly one Req high, SHALL grant that port; with both high, SHALL grant the port not granted last (round-robin); with none, SHALL stay in IDLE.
REQ-007 On grant, SHALL latch address, write data, D_Write and IorD into registers that drive the Mem_* outputs and IorD.
REQ-008 The fetch port SHALL only read.
REQ-009 A data grant with D_Write=1 SHALL go to WRITE; every other grant SHALL go to READ.
REQ-010 WRITE SHALL last exactly 1 cycle with Mem_Write=1, then go to RESP.
REQ-011 Mem_Write SHALL be 0 in every state other than WRITE.
REQ-012 READ SHALL last exactly RD_LAT cycles, counted by a 3-bit wait counter.
REQ-013 Mem_RData SHALL be captured into the granted port's RData register on the last READ cycle.
REQ-014 RESP SHALL last 1 cycle, pulse the granted port's Ack, then go to IDLE.
REQ-015 Latency from the grant cycle to the Ack cycle SHALL be RD_LAT+1 for a read and 2 for a write.
REQ-016 Requesters SHALL drop Req at the clock edge that ends the Ack cycle, so IDLE never re-grants a completed request.
REQ-017 A Req dropped mid-transaction SHALL NOT abort it: the transaction completes and Ack still pulses.
REQ-018 IF_RData and D_RData SHALL hold their last captured value until the next read for that port.
REQ-019 The last-grant register SHALL update on every grant.

Reset
REQ-020 Reset SHALL force IDLE, clear the wait counter and zero every output register (Acks, RData, Mem_*, IorD) on the next edge.
REQ-021 Reset SHALL set last-grant to data, so the first tie goes to fetch.
REQ-022 Reset asserted mid-transaction SHALL abort it with no Ack and Mem_Write=0 from the following cycle.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the state enum, the port-id typedef (PORT_IF, PORT_D) and the RD_LAT default constant.
REQ-024 The two-way round-robin pick SHALL be the sub-module rr_arb2 (inputs: two requests plus last grant; output: winner).
REQ-025 The counter and FSM SHALL stay in mem_arbiter.

Verification (RD_LAT=2)
REQ-026 Fetch read, IF_Addr=0x40, Mem_RData=0x8C020004 -> IF_Ack high exactly 3 cycles after the grant cycle, IF_RData=0x8C020004, IorD=0 throughout.
REQ-027 Store, D_Addr=0x100, D_WData=0xDEADBEEF -> one-cycle Mem_Write with Mem_Addr=0x100 and Mem_WData=0xDEADBEEF, D_Ack 2 cycles after grant.
REQ-028 IF_Req and D_Req raised in the same cycle after reset -> fetch served first, data second; then both re-raised -> fetch then data again (alternation).
REQ-029 Reset pulsed on the second READ cycle -> no Ack, next cycle IDLE with Busy=0 and all outputs 0.
REQ-030 D_Req dropped one cycle after grant -> transaction completes and D_Ack still pulses once.
REQ-031 Continuous IF_Req for 10 transactions -> 4 cycles per fetch, no lost or duplicate Ack.
